// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the MSB-first bit serializer.
// The PARITY state exists only when SERIALIZER_PARITY_EN is defined.
package serial_pkg;

  localparam int unsigned SER_WIDTH_DEFAULT = 8;

  function automatic int unsigned ser_cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int unsigned SER_CNT_W_DEFAULT = ser_cnt_width(SER_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SERIALIZER_PARITY_EN
    , PARITY
`endif
  } state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-word load handshake between a word producer and bit_serializer.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;

  modport master (output load_data, output load_valid, input load_ready);
  modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/bit_serializer.sv
// PISO stage: accepts a WIDTH-bit word and shifts it out MSB-first on b_out.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the LSB.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_serializer_if.slave      load,
  output logic                 b_out,
  output logic                 b_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned    CW   = ser_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             final_bit;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             parity;
`endif

  // Final-bit cycle doubles as a ready cycle so words can stream with no gap.
  always_comb begin
    final_bit = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    final_bit = (state == PARITY);
`else
    final_bit = (state == SHIFT) && (cnt == LAST);
`endif
  end

  assign load.load_ready = (state == IDLE) || final_bit;
  assign accept          = load.load_valid && load.load_ready;

  // shreg always holds the bit on b_out in its MSB; b_out is loaded one step ahead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      b_out   <= 1'b0;
      b_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity  <= 1'b0;
`endif
    end else if (accept) begin
      state   <= SHIFT;
      shreg   <= load.load_data;
      cnt     <= '0;
      b_out   <= load.load_data[WIDTH-1];
      b_valid <= 1'b1;
      busy    <= 1'b1;
      done    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity  <= ^load.load_data;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
            state <= PARITY;
            b_out <= parity;
            done  <= 1'b1;
`else
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            b_out   <= 1'b0;
            b_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`endif
          end else begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            b_out <= shreg[WIDTH-2];
            cnt   <= cnt + CW'(1);
`ifndef SERIALIZER_PARITY_EN
            done  <= (cnt == LAST - CW'(1));
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          state   <= IDLE;
          shreg   <= '0;
          cnt     <= '0;
          b_out   <= 1'b0;
          b_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=8), with a serial "110" detector model.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int L = 9;
`else
  localparam int L = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_out, b_valid, busy, done;
  logic [1:0] hist;
  logic det;

  int vectors    = 0;
  int miscompares = 0;

  bit_serializer_if #(.WIDTH(8)) lif ();

  bit_serializer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (lif),
    .b_out   (b_out),
    .b_valid (b_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Downstream "110" detector: d rises the cycle after the completing 0.
  always @(posedge clk) begin
    if (rst) begin
      hist <= 2'b00;
      det  <= 1'b0;
    end else begin
      det  <= (hist == 2'b11) && !b_out;
      hist <= {hist[0], b_out};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data  = 8'h00;
    tick();
    tick();
    vectors++;
    if ({b_out, b_valid, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0000", {b_out, b_valid, busy, done});
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (lif.load_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", lif.load_ready);
    end
    vectors++;
    if ({b_out, b_valid, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_outputs: got %b want 0000", {b_out, b_valid, busy, done});
    end
  endtask

  task automatic test_single_word(input logic [7:0] w);
    logic exp_bit;
    lif.load_data  = w;
    lif.load_valid = 1'b1;
    tick();
    lif.load_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      exp_bit = (i < 8) ? w[7-i] : ^w;
      vectors++;
      if (b_out !== exp_bit || b_valid !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL single_%h_bit%0d: got b=%b v=%b busy=%b want b=%b v=1 busy=1",
                 w, i, b_out, b_valid, busy, exp_bit);
      end
      vectors++;
      if (done !== (i == L-1) || lif.load_ready !== (i == L-1)) begin
        miscompares++;
        $display("FAIL single_%h_done_ready%0d: got done=%b ready=%b want %b",
                 w, i, done, lif.load_ready, (i == L-1));
      end
      tick();
    end
    vectors++;
    if ({b_out, b_valid, busy, done, lif.load_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL single_%h_after: got %b want 00001", w,
               {b_out, b_valid, busy, done, lif.load_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic exp_bit;
    lif.load_data  = 8'hFF;
    lif.load_valid = 1'b1;
    tick();
    lif.load_data  = 8'h00;
    for (int k = 0; k < 2*L; k++) begin
      exp_bit = (k < 8) ? 1'b1 : 1'b0;
      vectors++;
      if (b_out !== exp_bit || b_valid !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_bit%0d: got b=%b v=%b busy=%b want b=%b v=1 busy=1",
                 k, b_out, b_valid, busy, exp_bit);
      end
      vectors++;
      if (done !== (k == L-1 || k == 2*L-1)) begin
        miscompares++;
        $display("FAIL b2b_done%0d: got %b want %b", k, done, (k == L-1 || k == 2*L-1));
      end
      tick();
      if (k == L-1) lif.load_valid = 1'b0;
    end
    vectors++;
    if ({b_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_after: got %b want 00", {b_valid, busy});
    end
  endtask

  task automatic test_ignore_and_reset_mid();
    lif.load_data  = 8'hB6;
    lif.load_valid = 1'b1;
    tick();                               // cycle N+1
    lif.load_valid = 1'b0;
    tick();                               // cycle N+2
    lif.load_data  = 8'h00;
    lif.load_valid = 1'b1;
    vectors++;
    if (lif.load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ready: got %b want 0", lif.load_ready);
    end
    tick();                               // cycle N+3: third bit of B6
    vectors++;
    if (b_out !== 1'b1 || busy !== 1'b1 || b_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_load: got b=%b busy=%b v=%b want 1 1 1", b_out, busy, b_valid);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({b_out, b_valid, busy, done, lif.load_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL mid_reset: got %b want 00001",
               {b_out, b_valid, busy, done, lif.load_ready});
    end
    rst = 1'b0;
    lif.load_valid = 1'b0;
    tick();
    vectors++;
    if ({b_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset_not_accepted: got %b want 00", {b_valid, busy});
    end
    tick();
  endtask

  task automatic test_detect();
    // 6C = 01101100: "110" completes at cycles N+4 and N+7.
    lif.load_data  = 8'h6C;
    lif.load_valid = 1'b1;
    tick();
    lif.load_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (det !== (i == 4 || i == 7)) begin
        miscompares++;
        $display("FAIL detect_6c_cyc%0d: got d=%b want %b", i, det, (i == 4 || i == 7));
      end
      tick();
    end
    tick();
    // 03 then 00: the "110" straddles the word boundary.
    lif.load_data  = 8'h03;
    lif.load_valid = 1'b1;
    tick();
    lif.load_data  = 8'h00;
    for (int k = 0; k < 2*L; k++) begin
      vectors++;
      if (det !== (k == 9)) begin
        miscompares++;
        $display("FAIL detect_boundary_cyc%0d: got d=%b want %b", k, det, (k == 9));
      end
      tick();
      if (k == L-1) lif.load_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_word(8'hB6);
    tick();
    test_single_word(8'h01);
    tick();
    test_back_to_back();
    tick();
    test_ignore_and_reset_mid();
    test_detect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial (PISO) stage that sits directly upstream of the serial "110" sequence detector. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk, on b_out. It drives b_out straight into the detector's serial input. It also gives bit-valid, busy and end-of-word indications for control/test logic.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
load_data  in  WIDTH  parallel word to serialize
load_valid  in  1  load_data is valid
load_ready  out  1  block can accept a word this cycle
b_out  out  1  serial bit, MSB first; feeds detector b input
b_valid  out  1  b_out carries a real data or parity bit
busy  out  1  word in flight (state != IDLE)
done  out  1  one-cycle pulse coincident with final serial bit of a word

Behaviour:
- Interface: one clk; reset is synchronous and active-high (rst sampled on posedge clk). No async paths.
- Reset values: state=IDLE, shift register=0, bit count=0, b_out=0, b_valid=0, done=0, busy=0. load_ready=1 from the first cycle after reset.
- Handshake: a word is accepted on an edge where load_valid && load_ready. load_data must be held stable with load_valid until accepted. A word is never dropped or duplicated.
- load_ready is combinational from registered state: 1 in IDLE, and 1 in the cycle presenting the final bit of a word (back-to-back support). Otherwise 0.
- States:
  - IDLE: b_valid=0, b_out=0. Accept → SHIFT, count=0.
  - SHIFT: b_out=shreg[WIDTH-1], b_valid=1. Each edge shifts left by 1 and increments count.
  - At count==WIDTH-1: without PARITY_EN, go to SHIFT (new word accepted same edge) or IDLE. With PARITY_EN, go to PARITY.
  - PARITY (feature only): b_out=stored parity bit, b_valid=1, one cycle. Then SHIFT (if accepted) or IDLE.
- Latency: word accepted at edge N; MSB appears in the cycle after N; bit i (MSB=0) appears in cycle N+1+i. The last data bit appears in cycle N+WIDTH.
- All outputs except load_ready are registered.
- done=1 exactly in the cycle of the final bit (data LSB, or parity bit with feature).
- Back-to-back: a word accepted during the final-bit cycle produces its MSB in the very next cycle. There is no idle gap and no b_valid drop.
- Gaps: between words b_out is forced to 0. The downstream detector sees zeros, which is required: a gap terminates any pending "11" prefix.
- Reset mid-word: the in-flight word is discarded. The cycle after rst, all outputs are at reset values. rst has priority over simultaneous load_valid.
- load_valid while busy and not in final-bit cycle: ignored (ready=0). No state change.
- Counter width: $clog2(WIDTH). Count never exceeds WIDTH-1.

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- Defined: even-parity bit (XOR-reduce of load_data) is captured at accept and emitted as one extra serial bit after the LSB. A word occupies WIDTH+1 cycles. load_ready and done move to the parity cycle.
- Undefined: no PARITY state or parity register is compiled. A word occupies WIDTH cycles.

Decomposition:
- Shared package serial_pkg:
  - state enum (IDLE, SHIFT, PARITY)
  - SER_WIDTH_DEFAULT=8
  - the count-width localparam expression
- No sub-module. The shift register, counter and FSM are small and tightly coupled, so they belong in one module.

Test Plan:
- WIDTH=8, reset then load 8'hB6 at edge N → b_out=1,0,1,1,0,1,1,0 in cycles N+1..N+8, b_valid=1 throughout, done only at N+8; then IDLE with b_out=0, b_valid=0.
- Same with SERIALIZER_PARITY_EN → parity bit 1 (five ones) at N+9, done at N+9, load_ready low in N+8 and high in N+9.
- Back-to-back 8'hFF then 8'h00, load_valid held → 16 contiguous valid bits (eight 1s then eight 0s), no gap. The second word is accepted on the edge ending cycle N+8.
- rst asserted in cycle N+3 mid-word, with load_valid also high → next cycle all outputs at reset values, load_ready=1, and the word is not accepted.
- Load 8'h6C (01101100) with detector attached → detector d=1 for the cycle after the "110" sequence completes. Two-word stream 8'h03, 8'h00 → "110" spans the word boundary and is still detected.
